// File: rtl/ss_bram_capture.sv
// Snapshot capture buffer: arm/trigger controller with a dual-port sample RAM.
// Optional pre-trigger circular capture while armed: define SS_PRETRIG_EN.
module ss_bram_capture #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  localparam int LANES = DATA_WIDTH / 32,
  localparam int LW = $clog2(LANES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     din_valid,
  input  logic                     arm,
  input  logic                     trig,
  input  logic [ADDR_WIDTH:0]      cap_len,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_WIDTH:0]      wr_count,
  output logic [ADDR_WIDTH-1:0]    trig_addr,
  input  logic                     rd_en,
  input  logic [ADDR_WIDTH+LW-1:0] rd_addr,
  output logic [31:0]              rd_data,
  output logic                     rd_valid
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE, S_ARMED, S_CAP, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d, cnt_inc;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   eff_len;
  logic                  we;

  assign eff_len = (cap_len == '0 || cap_len > DEPTH_L)
                 ? DEPTH_L : cap_len;
  assign cnt_inc = cnt_q + 1'b1;

`ifdef SS_PRETRIG_EN
  logic [ADDR_WIDTH-1:0] taddr_q, taddr_d;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    we      = 1'b0;
`ifdef SS_PRETRIG_EN
    taddr_d = taddr_q;
`endif
    if (arm) begin
      // re-arm wins over any write qualified this cycle
      state_d = S_ARMED;
      len_d   = eff_len;
      cnt_d   = '0;
      ptr_d   = '0;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (trig) begin
            state_d = S_CAP;
`ifdef SS_PRETRIG_EN
            taddr_d = ptr_q;
`endif
          end
          if (din_valid && trig) begin
            we    = 1'b1;
            ptr_d = ptr_q + 1'b1;
            cnt_d = cnt_inc;
            if (cnt_inc == len_q) state_d = S_DONE;
          end
`ifdef SS_PRETRIG_EN
          else if (din_valid) begin
            we    = 1'b1;
            ptr_d = ptr_q + 1'b1;
          end
`endif
        end
        S_CAP: begin
          if (din_valid) begin
            we    = 1'b1;
            ptr_d = ptr_q + 1'b1;
            cnt_d = cnt_inc;
            if (cnt_inc == len_q) state_d = S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
`ifdef SS_PRETRIG_EN
      taddr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
`ifdef SS_PRETRIG_EN
      taddr_q <= taddr_d;
`endif
    end
  end

  assign busy     = (state_q == S_ARMED) || (state_q == S_CAP);
  assign done     = (state_q == S_DONE);
  assign wr_count = cnt_q;
`ifdef SS_PRETRIG_EN
  assign trig_addr = taddr_q;
`else
  assign trig_addr = '0;
`endif

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;
  logic [ADDR_WIDTH-1:0] rsamp;
  logic [31:0]           lane_word;
  logic                  v1_q;
  logic                  rd_valid_q;
  logic [31:0]           rd_data_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[ptr_q] <= din;
  end

  // read-first: the old word is captured on a same-address write
  always_ff @(posedge clk) begin
    if (rd_en) ram_q <= mem_q[rsamp];
  end

  generate
    if (LW == 0) begin : g_one
      assign rsamp     = rd_addr;
      assign lane_word = ram_q[31:0];
    end else begin : g_multi
      logic [LW-1:0]             lane_q;
      logic [LANES-1:0][31:0]    ram_w;
      assign rsamp = rd_addr[ADDR_WIDTH+LW-1:LW];
      assign ram_w = ram_q;
      always_ff @(posedge clk) begin
        if (rd_en) lane_q <= rd_addr[LW-1:0];
      end
      assign lane_word = ram_w[lane_q];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      v1_q       <= rd_en;
      rd_valid_q <= v1_q;
      if (v1_q) rd_data_q <= lane_word;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_ss_bram_capture.sv
// Scoreboard bench for ss_bram_capture: 32-bit and 64-bit instances.
// Reads are queued at issue and checked by a monitor on rd_valid.
module tb_ss_bram_capture;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   din;
  logic [63:0]   din64;
  logic          din_valid, arm, trig;
  logic [AW:0]   cap_len;
  logic          busy, done, busy64, done64;
  logic [AW:0]   wr_count, wr_count64;
  logic [AW-1:0] trig_addr, trig_addr64;
  logic          rd_en, rd_en64;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rd_addr64;
  logic [31:0]   rd_data, rd_data64;
  logic          rd_valid, rd_valid64;

  int cyc = 0;
  int ncmp = 0;
  int nfail = 0;

  typedef struct {
    int          c;
    logic [31:0] d;
  } exp_t;
  exp_t q32[$];
  exp_t q64[$];

  ss_bram_capture #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .arm(arm), .trig(trig), .cap_len(cap_len), .busy(busy),
    .done(done), .wr_count(wr_count), .trig_addr(trig_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid)
  );

  ss_bram_capture #(.DATA_WIDTH(64), .ADDR_WIDTH(AW)) dut64 (
    .clk(clk), .rst_n(rst_n), .din(din64), .din_valid(din_valid),
    .arm(arm), .trig(trig), .cap_len(cap_len), .busy(busy64),
    .done(done64), .wr_count(wr_count64), .trig_addr(trig_addr64),
    .rd_en(rd_en64), .rd_addr(rd_addr64), .rd_data(rd_data64),
    .rd_valid(rd_valid64)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon32
    exp_t e;
    if (rd_valid) begin
      ncmp++;
      if (q32.size() == 0) begin
        nfail++;
        $display("FAIL rd32 spurious rd_valid data=%h", rd_data);
      end else begin
        e = q32.pop_front();
        if (rd_data !== e.d || cyc != e.c + 2) begin
          nfail++;
          $display("FAIL rd32 got %h at cyc %0d, want %h at cyc %0d",
                   rd_data, cyc, e.d, e.c + 2);
        end
      end
    end
  end

  always @(negedge clk) begin : mon64
    exp_t e;
    if (rd_valid64) begin
      ncmp++;
      if (q64.size() == 0) begin
        nfail++;
        $display("FAIL rd64 spurious rd_valid data=%h", rd_data64);
      end else begin
        e = q64.pop_front();
        if (rd_data64 !== e.d || cyc != e.c + 2) begin
          nfail++;
          $display("FAIL rd64 got %h at cyc %0d, want %h at cyc %0d",
                   rd_data64, cyc, e.d, e.c + 2);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] d);
    din_valid = 1'b1;
    din = d;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic rd32(input logic [AW-1:0] a, input logic [31:0] d);
    rd_en = 1'b1;
    rd_addr = a;
    q32.push_back('{cyc, d});
    tick();
  endtask

  task automatic rd64(input logic [AW:0] a, input logic [31:0] d);
    rd_en64 = 1'b1;
    rd_addr64 = a;
    q64.push_back('{cyc, d});
    tick();
  endtask

  task automatic rdoff();
    rd_en = 1'b0;
    rd_en64 = 1'b0;
    repeat (4) tick();
  endtask

  task automatic do_arm(input logic [AW:0] len);
    cap_len = len;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    int w;
    din = '0; din64 = '0; din_valid = 0; arm = 0; trig = 0;
    cap_len = '0; rd_en = 0; rd_addr = '0; rd_en64 = 0; rd_addr64 = '0;
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst wr_count", wr_count, 0);
    chk("rst trig_addr", trig_addr, 0);
    chk("rst rd_valid", rd_valid, 0);
    chk("rst rd_data", rd_data, 0);
    chk("rst busy64", busy64, 0);
    rst_n = 1'b1;
    tick();

    // basic 4-sample capture with a gap
    do_arm(4);
    chk("t1 armed busy", busy, 1);
    chk("t1 armed done", done, 0);
    trig = 1'b1;
    wr(32'hA0);
    trig = 1'b0;
    wr(32'hA1);
    tick();
    chk("t1 gap count", wr_count, 2);
    wr(32'hA2);
    chk("t1 not done", done, 0);
    wr(32'hA3);
    chk("t1 done", done, 1);
    chk("t1 busy", busy, 0);
    chk("t1 wr_count", wr_count, 4);
    wr(32'hEE);
    chk("t1 overrun count", wr_count, 4);
    for (int i = 0; i < 4; i++) rd32(AW'(i), 32'hA0 + i);
    rdoff();

    // 64-bit lane ordering
    do_arm(2);
    trig = 1'b1;
    din_valid = 1'b1;
    din64 = 64'h11112222_33334444;
    tick();
    trig = 1'b0;
    din64 = 64'h55556666_77778888;
    tick();
    din_valid = 1'b0;
    chk("t2 done64", done64, 1);
    chk("t2 wr_count64", wr_count64, 2);
    rd64(0, 32'h33334444);
    rd64(1, 32'h11112222);
    rd64(2, 32'h77778888);
    rd64(3, 32'h55556666);
    rdoff();

    // cap_len=0 means full depth
    do_arm(0);
    trig = 1'b1;
    wr(32'h1000);
    trig = 1'b0;
    for (int i = 1; i < 1024; i++) begin
      if (i == 1023) chk("t3 not done early", done, 0);
      wr(32'h1000 + i);
    end
    chk("t3 done", done, 1);
    chk("t3 wr_count", wr_count, 1024);
    wr(32'h2000);
    chk("t3 sat count", wr_count, 1024);
    rd32(0, 32'h1000);
    rd32(1023, 32'h13FF);
    rd32(4, 32'h1004);
    rdoff();

    // re-arm mid capture
    do_arm(8);
    trig = 1'b1;
    wr(32'hB0);
    trig = 1'b0;
    wr(32'hB1);
    wr(32'hB2);
    chk("t4 count3", wr_count, 3);
    cap_len = 2;
    arm = 1'b1;
    din_valid = 1'b1;
    din = 32'hBF;
    tick();
    arm = 1'b0;
    din_valid = 1'b0;
    chk("t4 rearm busy", busy, 1);
    chk("t4 rearm done", done, 0);
    chk("t4 rearm count", wr_count, 0);
    tick();
    chk("t4 still armed", wr_count, 0);
    trig = 1'b1;
    wr(32'hC0);
    trig = 1'b0;
    wr(32'hC1);
    chk("t4 done", done, 1);
    chk("t4 wr_count", wr_count, 2);
    rd32(0, 32'hC0);
    rd32(1, 32'hC1);
    rd32(2, 32'hB2);
    rd32(3, 32'h1003);
    rdoff();

    // reset during capture, then read-first on recapture
    do_arm(4);
    trig = 1'b1;
    wr(32'hE0);
    trig = 1'b0;
    wr(32'hE1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5 busy", busy, 0);
    chk("t5 done", done, 0);
    chk("t5 wr_count", wr_count, 0);
    chk("t5 rd_valid", rd_valid, 0);
    do_arm(4);
    trig = 1'b1;
    rd_en = 1'b1;
    rd_addr = 0;
    q32.push_back('{cyc, 32'hE0});
    wr(32'hD0);
    trig = 1'b0;
    rd_en = 1'b0;
    wr(32'hD1);
    wr(32'hD2);
    wr(32'hD3);
    chk("t5 done", done, 1);
    chk("t5 wr_count", wr_count, 4);
    chk("t5 trig_addr", trig_addr, 0);
    for (int i = 0; i < 4; i++) rd32(AW'(i), 32'hD0 + i);
    rdoff();

    // trig ignored in DONE; held trig re-triggers after arm
    trig = 1'b1;
    tick();
    chk("t6 done hold", done, 1);
    chk("t6 busy hold", busy, 0);
    do_arm(1);
    tick();
    chk("t6 capture busy", busy, 1);
    trig = 1'b0;
    wr(32'h77);
    chk("t6 done", done, 1);
    chk("t6 wr_count", wr_count, 1);
    rd32(0, 32'h77);
    rdoff();

`ifdef SS_PRETRIG_EN
    do_arm(4);
    for (int i = 0; i < 1030; i++) wr(32'(i));
    chk("pt armed count", wr_count, 0);
    chk("pt armed busy", busy, 1);
    trig = 1'b1;
    wr(32'd1030);
    trig = 1'b0;
    chk("pt trig_addr", trig_addr, 6);
    for (int i = 1031; i < 1034; i++) wr(32'(i));
    chk("pt done", done, 1);
    rd32(5, 32'd1029);
    for (int i = 6; i < 10; i++) rd32(AW'(i), 32'(1024 + i));
    rdoff();
`endif

    w = 0;
    while ((q32.size() != 0 || q64.size() != 0) && w < 20) begin
      tick();
      w++;
    end
    if (q32.size() != 0 || q64.size() != 0) begin
      ncmp++;
      nfail++;
      $display("FAIL drain reads outstanding %0d/%0d, want 0",
               q32.size(), q64.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
